// File: rtl/caminho_dados.sv
// Register-and-ALU datapath of the calculator: X operand, Y accumulator/shifter, Z result.
// All updates are gated by the single-cycle valid strobe and take effect on one edge.
module caminho_dados #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       auxX,
    input  logic [2:0]       auxY,
    input  logic [1:0]       auxZ,
    input  logic             auxULA,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] regX,
    output logic [WIDTH-1:0] regY,
    output logic [WIDTH-1:0] regZ,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    // Carry/borrow lands in the extra top bit; a negative difference wraps so that bit is the borrow.
    function automatic logic [WIDTH:0] alu(input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] x,
                                           input logic sub);
        logic [WIDTH:0] r;
        if (sub)
            r = {1'b0, y} - {1'b0, x};
        else
            r = {1'b0, y} + {1'b0, x};
        return r;
    endfunction

    logic [WIDTH:0]   alu_res;
    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic [WIDTH-1:0] z_nxt;
    logic             c_nxt;

    assign alu_res = alu(regY, regX, auxULA);

    always_comb begin
        x_nxt = regX;
        y_nxt = regY;
        z_nxt = regZ;
        c_nxt = carry;

        case (auxX)
            2'b00:   x_nxt = '0;
            2'b01:   x_nxt = data_in;
            default: x_nxt = regX;
        endcase

        case (auxY)
            3'b000: begin
                y_nxt = '0;
                c_nxt = 1'b0;
            end
            3'b001: begin
                y_nxt = alu_res[WIDTH-1:0];
                c_nxt = alu_res[WIDTH];
            end
            3'b011: begin
                y_nxt = {regY[WIDTH-2:0], 1'b0};
                c_nxt = regY[WIDTH-1];
            end
            3'b100: begin
                y_nxt = {1'b0, regY[WIDTH-1:1]};
                c_nxt = regY[0];
            end
            default: begin
                y_nxt = regY;
                c_nxt = carry;
            end
        endcase

        case (auxZ)
            2'b00:   z_nxt = '0;
            2'b01:   z_nxt = regY;
            default: z_nxt = regZ;
        endcase
    end

    // Commit stage: zero is computed from next-state Y so it never lags regY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regX  <= '0;
            regY  <= '0;
            regZ  <= '0;
            carry <= 1'b0;
            zero  <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= valid;
            if (valid) begin
                regX  <= x_nxt;
                regY  <= y_nxt;
                regZ  <= z_nxt;
                carry <= c_nxt;
                zero  <= (y_nxt == '0);
            end
        end
    end

endmodule

// File: doc/caminho_dados.md
# caminho_dados

Register-and-ALU datapath of the calculator, directly downstream of the control decoder. Consumes the decoder's per-register command codes (X, Y, Z) and the ALU select, and holds the three architectural registers: X (operand input), Y (accumulator, shiftable), and Z (result/display). All state changes are qualified by a single-cycle `valid` strobe. Registered carry and zero flags and a `done` pulse are provided to the upstream sequencer.

## Interface
- `WIDTH`, 8: data width of X, Y, Z, `data_in` and the ALU.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid` in 1: command strobe; codes below are applied only on edges where `valid`=1.
- `auxX` in 2: X command. 00 clear, 01 load `data_in`, 10/11 hold.
- `auxY` in 3: Y command. 000 clear, 001 load ALU result, 010 hold, 011 shift left, 100 shift right, 101–111 hold.
- `auxZ` in 2: Z command. 00 clear, 01 load Y, 10/11 hold.
- `auxULA` in 1: ALU op. 0 = Y + X, 1 = Y − X.
- `data_in` in WIDTH: external operand.
- `regX`, `regY`, `regZ` out WIDTH: register contents.
- `carry` out 1: carry, borrow or shifted-out bit.
- `zero` out 1: 1 when `regY` == 0.
- `done` out 1: one-cycle pulse acknowledging an applied command.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - `regX`, `regY`, `regZ`, `carry` and `done` go to 0.
  - `zero` goes to 1.
  - Reset dominates any in-flight command; no partial update survives.
- ALU (combinational, WIDTH+1 bits internally):
  - Add: {c, r} = Y + X.
  - Subtract: r = Y − X mod 2^WIDTH; c = 1 iff Y < X (unsigned borrow).
- On a rising edge with `valid`=1, all three registers update simultaneously.
  - Every source operand is the pre-edge value.
  - Example: X load together with Y load gives Y ← oldY ± oldX and X ← `data_in`.
  - Example: Z load together with Y clear gives Z ← oldY and Y ← 0.
- Y shift left: Y ← {Y[WIDTH-2:0], 0}; `carry` ← old Y[WIDTH-1].
- Y shift right (logical): Y ← {0, Y[WIDTH-1:1]}; `carry` ← old Y[0].
- `carry` update rules:
  - Y load: `carry` ← c.
  - Y clear: `carry` ← 0.
  - Y hold or reserved code: `carry` held.
- `zero` always reflects the registered Y (next-state compare, registered). It never lags `regY`.
- `valid`=0: all registers and flags hold, regardless of the command codes.
- Reserved codes (auxX/auxZ 11, auxY 101–111) behave as hold. They are not errors.

## Timing
- Latency is 1 cycle: a command sampled at edge N is visible on `regX`/`regY`/`regZ`/`carry`/`zero` after edge N.
- `done` is 1 for exactly the cycle after each edge with `valid`=1, else 0.
- Back-to-back `valid` keeps `done` high continuously. Each edge applies one command, with no bubbles.
- No combinational path from any input to any output.
- Arithmetic wraps modulo 2^WIDTH; overflow is reported only through `carry`.

## Test plan
- Reset mid-operation:
  - Load X=0x55 and Y=0x10.
  - Assert `rst_n`=0 between edges → all registers 0, `zero`=1, `carry`=0, `done`=0 immediately, without waiting for a clock edge.
- Calculator sequence (WIDTH=8):
  - auxX=01/auxY=000/auxZ=00 with `data_in`=5 → X=5, Y=0, Z=0.
  - Then auxX=01/auxY=001/auxZ=10, add, `data_in`=3 → Y=5, X=3.
  - Then auxX=10/auxY=001, sub → Y=2, `carry`=0.
- Overflow and borrow:
  - X=200, Y=100, add → Y=44, `carry`=1.
  - X=3, Y=2, sub → Y=0xFF, `carry`=1, `zero`=0.
- Shifts:
  - Y=0x81, shift left → Y=0x02, `carry`=1.
  - Y=0x03, shift right → Y=0x01, `carry`=1.
  - Y=0x01, shift right → Y=0x00, `carry`=1, `zero`=1.
- Gating:
  - `valid`=0 for 4 cycles with auxX=01/auxY=001/auxZ=01 and varying `data_in` → no register or flag change, `done`=0.
  - Then `valid`=1 for 3 consecutive cycles → `done` high for 3 cycles and 3 updates applied.
- Simultaneous Z load with Y clear:
  - Y=2, auxX=00/auxY=000/auxZ=01 → Z=2, Y=0, X=0, `zero`=1, `carry`=0.
